stage3_store_buffer: RTL and testbench

//  Posted-write buffer between the stage3 memory stage data port and the data cache/bus.

---
 rtl/stage3_store_buffer_if.sv | 40 ++++
 rtl/stage3_store_buffer.sv | 141 ++++++++++++++
 tb/tb_stage3_store_buffer.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stage3_store_buffer_if.sv
// CPU data port, downstream memory port and fence handshake of the stage3 store buffer.
// master = the mem stage / memory side that drives requests and responses; slave = the buffer.
interface stage3_store_buffer_if;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_byte_en;
  logic        cpu_ren;
  logic        cpu_wen;
  logic [31:0] cpu_rdata;
  logic        cpu_busy;
  logic        cpu_error;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byte_en;
  logic        mem_ren;
  logic        mem_wen;
  logic [31:0] mem_rdata;
  logic        mem_busy;
  logic        mem_error;
  logic        drain_req;
  logic        drain_done;
  logic        store_fault;
  logic [31:0] fault_addr;

  modport master (
    output cpu_addr, cpu_wdata, cpu_byte_en, cpu_ren, cpu_wen,
    output mem_rdata, mem_busy, mem_error, drain_req,
    input  cpu_rdata, cpu_busy, cpu_error,
    input  mem_addr, mem_wdata, mem_byte_en, mem_ren, mem_wen,
    input  drain_done, store_fault, fault_addr
  );

  modport slave (
    input  cpu_addr, cpu_wdata, cpu_byte_en, cpu_ren, cpu_wen,
    input  mem_rdata, mem_busy, mem_error, drain_req,
    output cpu_rdata, cpu_busy, cpu_error,
    output mem_addr, mem_wdata, mem_byte_en, mem_ren, mem_wen,
    output drain_done, store_fault, fault_addr
  );
endinterface

// File: rtl/stage3_store_buffer.sv
// Posted-write store buffer: stores retire in 0 cycles when a slot is free (busy when full),
// loads forward from the youngest covering entry or wait for the buffer to drain, then read through.
module stage3_store_buffer #(
  parameter int DEPTH  = 4,
  parameter bit FWD_EN = 1'b1
) (
  input logic            CLK,
  input logic            nRST,
  stage3_store_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [3:0]  byte_en;
  } entry_t;

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

  state_t          state, state_nx;
  entry_t          ent [DEPTH];
  logic [PW-1:0]   head, tail;
  logic [CW-1:0]   count;
  logic            fault;
  logic [31:0]     fault_a;
  logic            pend;

  logic            full, deq, enq, drain_hit;
  logic            fwd_hit, fwd_cover, fwd_ok;
  logic [PW-1:0]   fwd_idx;

  assign full      = (count == CW'(DEPTH));
  assign deq       = nRST && (state == WRITE) && !bus.mem_busy;
  assign enq       = nRST && bus.cpu_wen && (!full || deq);
  assign drain_hit = pend && (count == '0) && (state != WRITE);

  // Oldest-to-youngest scan; the last hit is the youngest matching word.
  always_comb begin
    fwd_hit = 1'b0;
    fwd_idx = head;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < count) && (ent[head + PW'(i)].addr == bus.cpu_addr[31:2])) begin
        fwd_hit = 1'b1;
        fwd_idx = head + PW'(i);
      end
    end
  end

  assign fwd_cover = ((ent[fwd_idx].byte_en & bus.cpu_byte_en) == bus.cpu_byte_en);
  assign fwd_ok    = FWD_EN && fwd_hit && fwd_cover && !(deq && (fwd_idx == head));

  always_comb begin
    bus.cpu_rdata   = '0;
    bus.cpu_busy    = 1'b0;
    bus.cpu_error   = 1'b0;
    bus.mem_addr    = '0;
    bus.mem_wdata   = '0;
    bus.mem_byte_en = '0;
    bus.mem_ren     = 1'b0;
    bus.mem_wen     = 1'b0;
    state_nx        = state;
    if (nRST) begin
      case (state)
        IDLE: begin
          if (count != '0)
            state_nx = WRITE;
          else if (bus.cpu_ren && !bus.cpu_wen)
            state_nx = READ;
        end
        WRITE: begin
          bus.mem_wen     = 1'b1;
          bus.mem_addr    = {ent[head].addr, 2'b00};
          bus.mem_wdata   = ent[head].wdata;
          bus.mem_byte_en = ent[head].byte_en;
          if (!bus.mem_busy)
            state_nx = (count > CW'(1)) ? WRITE : IDLE;
        end
        READ: begin
          bus.mem_ren     = 1'b1;
          bus.mem_addr    = bus.cpu_addr;
          bus.mem_byte_en = bus.cpu_byte_en;
          if (!bus.mem_busy)
            state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase

      // A store always wins over a coincident load.
      if (bus.cpu_wen) begin
        bus.cpu_busy = !enq;
      end else if (bus.cpu_ren) begin
        if (state == READ) begin
          bus.cpu_busy  = bus.mem_busy;
          bus.cpu_rdata = bus.mem_rdata;
          bus.cpu_error = bus.mem_error;
        end else if ((count != '0) && fwd_ok) begin
          bus.cpu_rdata = ent[fwd_idx].wdata;
        end else begin
          bus.cpu_busy = 1'b1;
        end
      end
    end
  end

  assign bus.drain_done  = nRST && drain_hit;
  assign bus.store_fault = nRST && fault;
  assign bus.fault_addr  = nRST ? fault_a : 32'h0;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state   <= IDLE;
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      fault   <= 1'b0;
      fault_a <= '0;
      pend    <= 1'b0;
    end else begin
      state <= state_nx;
      if (enq)
        tail <= tail + 1'b1;
      if (deq) begin
        head <= head + 1'b1;
        if (bus.mem_error && !fault) begin
          fault   <= 1'b1;
          fault_a <= {ent[head].addr, 2'b00};
        end
      end
      count <= count + CW'(enq) - CW'(deq);
      pend  <= drain_hit ? 1'b0 : (pend | bus.drain_req);
    end
  end

  // Entry payload needs no reset; count alone decides validity.
  always_ff @(posedge CLK) begin
    if (enq)
      ent[tail] <= '{addr: bus.cpu_addr[31:2], wdata: bus.cpu_wdata, byte_en: bus.cpu_byte_en};
  end
endmodule

// File: tb/tb_stage3_store_buffer.sv
module tb_stage3_store_buffer;
  localparam int DEPTH = 4;

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  stage3_store_buffer_if bus();

  stage3_store_buffer #(.DEPTH(DEPTH), .FWD_EN(1'b1)) dut (
    .CLK (clk),
    .nRST(nrst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of pending stores plus the spec's mode rules.
  typedef struct packed {
    logic [29:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } ent_t;

  ent_t        q[$];
  int          mode = 0;  // 0 idle, 1 writing head, 2 reading through
  bit          m_fault = 0;
  logic [31:0] m_faddr = 0;
  bit          m_pend = 0;

  bit          e_busy, e_err, e_mwen, e_mren, e_dd, m_deq, m_enq, m_fwd;
  logic [31:0] e_rdata, e_maddr, e_mwdata;
  logic [3:0]  e_mbe;
  int          j, oldsize;

  always @(negedge clk) begin
    e_busy = 0; e_err = 0; e_rdata = 0; e_mwen = 0; e_mren = 0;
    e_maddr = 0; e_mwdata = 0; e_mbe = 0; e_dd = 0; m_fwd = 0;
    if (!nrst) begin
      chk("m_rst_busy", bus.cpu_busy, 0);
      chk("m_rst_mwen", bus.mem_wen, 0);
      chk("m_rst_mren", bus.mem_ren, 0);
      chk("m_rst_maddr", bus.mem_addr, 0);
      chk("m_rst_dd", bus.drain_done, 0);
      chk("m_rst_sf", bus.store_fault, 0);
      chk("m_rst_fa", bus.fault_addr, 0);
      q.delete();
      mode = 0; m_fault = 0; m_faddr = 0; m_pend = 0;
    end else begin
      m_deq = (mode == 1) && !bus.mem_busy;
      m_enq = bus.cpu_wen && ((q.size() < DEPTH) || m_deq);
      if (mode == 1) begin
        e_mwen = 1; e_maddr = {q[0].a, 2'b00}; e_mwdata = q[0].d; e_mbe = q[0].be;
      end else if (mode == 2) begin
        e_mren = 1; e_maddr = bus.cpu_addr; e_mbe = bus.cpu_byte_en;
      end
      if (bus.cpu_wen) begin
        e_busy = !m_enq;
      end else if (bus.cpu_ren) begin
        if (mode == 2) begin
          e_busy = bus.mem_busy; e_rdata = bus.mem_rdata; e_err = bus.mem_error;
        end else begin
          j = -1;
          for (int i = q.size() - 1; i >= 0; i--)
            if (j < 0 && q[i].a == bus.cpu_addr[31:2]) j = i;
          m_fwd = (j >= 0) && ((q[j].be & bus.cpu_byte_en) == bus.cpu_byte_en) && !(m_deq && j == 0);
          if (m_fwd) e_rdata = q[j].d;
          else e_busy = 1;
        end
      end
      e_dd = m_pend && (q.size() == 0) && (mode != 1);

      chk("m_busy", bus.cpu_busy, e_busy);
      if (bus.cpu_ren && !bus.cpu_wen && !e_busy) begin
        chk("m_rdata", bus.cpu_rdata, e_rdata);
        chk("m_err", bus.cpu_error, e_err);
      end
      chk("m_mwen", bus.mem_wen, e_mwen);
      chk("m_mren", bus.mem_ren, e_mren);
      chk("m_maddr", bus.mem_addr, e_maddr);
      chk("m_mbe", bus.mem_byte_en, e_mbe);
      if (e_mwen) chk("m_mwdata", bus.mem_wdata, e_mwdata);
      chk("m_dd", bus.drain_done, e_dd);
      chk("m_sf", bus.store_fault, m_fault);
      chk("m_fa", bus.fault_addr, m_faddr);

      oldsize = q.size();
      if (m_deq) begin
        if (bus.mem_error && !m_fault) begin
          m_fault = 1; m_faddr = {q[0].a, 2'b00};
        end
        void'(q.pop_front());
      end
      if (m_enq) q.push_back('{a: bus.cpu_addr[31:2], d: bus.cpu_wdata, be: bus.cpu_byte_en});
      case (mode)
        0: if (oldsize > 0) mode = 1; else if (bus.cpu_ren && !bus.cpu_wen) mode = 2;
        1: if (!bus.mem_busy) mode = (oldsize > 1) ? 1 : 0;
        default: if (!bus.mem_busy) mode = 0;
      endcase
      m_pend = e_dd ? 0 : (m_pend | bus.drain_req);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.cpu_wen = 1; bus.cpu_addr = a; bus.cpu_wdata = d; bus.cpu_byte_en = be;
    @(negedge clk);
    chk("store_accept", bus.cpu_busy, 0);
    tick();
    bus.cpu_wen = 0;
  endtask

  task automatic drain_wait(input string nm);
    bit got;
    got = 0;
    bus.drain_req = 1;
    tick();
    bus.drain_req = 0;
    for (int n = 0; n < 60 && !got; n++) begin
      @(negedge clk);
      if (bus.drain_done) got = 1;
      else tick();
    end
    chk(nm, got, 1);
    tick();
  endtask

  int  wcnt, stalls, pulses, at;
  bit  done;

  initial begin
    bus.cpu_addr = 0; bus.cpu_wdata = 0; bus.cpu_byte_en = 0;
    bus.cpu_ren = 0; bus.cpu_wen = 0;
    bus.mem_rdata = 0; bus.mem_busy = 0; bus.mem_error = 0; bus.drain_req = 0;
    repeat (3) @(posedge clk);
    #1 nrst = 1;
    @(negedge clk);
    chk("post_rst_mwen", bus.mem_wen, 0);
    chk("post_rst_busy", bus.cpu_busy, 0);
    tick();

    // Single store held by mem_busy for two cycles: three write cycles at 0x100.
    bus.mem_busy = 1;
    do_store(32'h100, 32'hDEADBEEF, 4'hF);
    wcnt = 0;
    for (int n = 0; n < 12; n++) begin
      if (wcnt == 2) bus.mem_busy = 0;
      @(negedge clk);
      if (bus.mem_wen) begin
        wcnt++;
        chk("t2_addr", bus.mem_addr, 32'h100);
        chk("t2_wdata", bus.mem_wdata, 32'hDEADBEEF);
      end
      tick();
    end
    chk("t2_wen_cycles", wcnt, 3);

    // Fill all four slots, fifth store stalls until the head drains.
    bus.mem_busy = 1;
    for (int i = 0; i < DEPTH; i++) do_store(32'h500 + 4 * i, 32'hA0 + i, 4'hF);
    bus.cpu_wen = 1; bus.cpu_addr = 32'h510; bus.cpu_wdata = 32'hA4; bus.cpu_byte_en = 4'hF;
    @(negedge clk);
    chk("t3_full_busy0", bus.cpu_busy, 1);
    tick();
    @(negedge clk);
    chk("t3_full_busy1", bus.cpu_busy, 1);
    tick();
    bus.mem_busy = 0;
    @(negedge clk);
    chk("t3_accept_on_deq", bus.cpu_busy, 0);
    chk("t3_head_addr", bus.mem_addr, 32'h500);
    tick();
    bus.cpu_wen = 0;
    drain_wait("t3_drain");

    // Forward a byte load from a full-word store.
    bus.mem_busy = 1;
    do_store(32'h200, 32'h11223344, 4'hF);
    bus.cpu_ren = 1; bus.cpu_addr = 32'h201; bus.cpu_byte_en = 4'b0010;
    @(negedge clk);
    chk("t4_busy", bus.cpu_busy, 0);
    chk("t4_rdata", bus.cpu_rdata, 32'h11223344);
    chk("t4_no_mren", bus.mem_ren, 0);
    tick();
    bus.cpu_ren = 0; bus.mem_busy = 0;
    drain_wait("t4_drain");

    // Youngest match wins; it must cover the load on its own.
    bus.mem_busy = 1;
    do_store(32'h600, 32'h01010101, 4'hF);
    do_store(32'h600, 32'h02020202, 4'b0011);
    bus.cpu_ren = 1; bus.cpu_addr = 32'h600; bus.cpu_byte_en = 4'b0011;
    @(negedge clk);
    chk("yng_busy", bus.cpu_busy, 0);
    chk("yng_rdata", bus.cpu_rdata, 32'h02020202);
    tick();
    bus.cpu_byte_en = 4'hF;
    @(negedge clk);
    chk("yng_nocover_busy", bus.cpu_busy, 1);
    tick();
    bus.cpu_ren = 0; bus.mem_busy = 0;
    drain_wait("yng_drain");

    // Matching head being dequeued cannot forward; load then reads through.
    bus.mem_busy = 1;
    do_store(32'h700, 32'h77, 4'hF);
    tick();
    bus.cpu_ren = 1; bus.cpu_addr = 32'h700; bus.cpu_byte_en = 4'hF;
    bus.mem_busy = 0; bus.mem_rdata = 32'h5A5A5A5A;
    @(negedge clk);
    chk("deq_block_busy", bus.cpu_busy, 1);
    done = 0;
    for (int n = 0; n < 20 && !done; n++) begin
      tick();
      @(negedge clk);
      if (!bus.cpu_busy) done = 1;
    end
    chk("deq_block_done", done, 1);
    chk("deq_block_rdata", bus.cpu_rdata, 32'h5A5A5A5A);
    chk("deq_block_mren", bus.mem_ren, 1);
    tick();
    bus.cpu_ren = 0;

    // Partial store does not cover a word load: stall, drain, read through.
    bus.mem_busy = 1;
    do_store(32'h300, 32'h000000AB, 4'b0001);
    bus.cpu_ren = 1; bus.cpu_addr = 32'h300; bus.cpu_byte_en = 4'hF;
    bus.mem_rdata = 32'hCAFEF00D;
    stalls = 0; done = 0;
    for (int n = 0; n < 30 && !done; n++) begin
      if (n == 2) bus.mem_busy = 0;
      @(negedge clk);
      if (!bus.cpu_busy) done = 1;
      else begin stalls++; tick(); end
    end
    chk("t5_done", done, 1);
    chk("t5_stalled", stalls >= 3, 1);
    chk("t5_mren", bus.mem_ren, 1);
    chk("t5_maddr", bus.mem_addr, 32'h300);
    chk("t5_rdata", bus.cpu_rdata, 32'hCAFEF00D);
    tick();
    bus.cpu_ren = 0; bus.mem_rdata = 0;

    // Drain on an empty buffer pulses the next cycle, exactly once.
    bus.drain_req = 1;
    tick();
    bus.drain_req = 0;
    @(negedge clk);
    chk("drain_empty_pulse", bus.drain_done, 1);
    tick();
    @(negedge clk);
    chk("drain_empty_once", bus.drain_done, 0);
    tick();

    // Faulting store, then drain: sticky fault and one drain pulse after empty.
    bus.mem_error = 1;
    do_store(32'h400, 32'h44, 4'hF);
    bus.drain_req = 1;
    tick();
    bus.drain_req = 0;
    pulses = 0; at = -1;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (bus.drain_done) begin pulses++; if (at < 0) at = n; end
      tick();
    end
    chk("t6_pulses", pulses, 1);
    chk("t6_pulse_cycle", at, 1);
    chk("t6_fault", bus.store_fault, 1);
    chk("t6_fault_addr", bus.fault_addr, 32'h400);
    do_store(32'h404, 32'h45, 4'hF);
    repeat (4) tick();
    @(negedge clk);
    chk("t6_first_fault_kept", bus.fault_addr, 32'h400);
    tick();
    bus.mem_error = 0;

    // Reset with two stores queued discards them and clears the fault.
    bus.mem_busy = 1;
    do_store(32'h800, 32'h88, 4'hF);
    do_store(32'h804, 32'h89, 4'hF);
    tick();
    nrst = 0;
    @(negedge clk);
    chk("t1_rst_mwen", bus.mem_wen, 0);
    chk("t1_rst_dd", bus.drain_done, 0);
    tick();
    nrst = 1; bus.mem_busy = 0;
    wcnt = 0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      if (bus.mem_wen) wcnt++;
      tick();
    end
    chk("t1_discarded", wcnt, 0);
    chk("t1_fault_clr", bus.store_fault, 0);
    chk("t1_faddr_clr", bus.fault_addr, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
